// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode, result-entry and datapath-width definitions
package alu_pkg;
  localparam int ALU_DATA_W = 8;
  typedef enum logic [2:0] {
    ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR = 3'd3,
    XOR = 3'd4, NOR = 3'd5, SHL = 3'd6, SHR = 3'd7
  } alu_op_t;
  typedef struct packed {
    alu_op_t                 opcode;
    logic                    carry;
    logic                    zero;
    logic [ALU_DATA_W-1:0]   result;
  } alu_entry_t;
endpackage

// File: rtl/alu_sat_counter.sv
// alu_sat_counter: saturating up-counter, async active-low reset
module alu_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: FWFT valid/ready FIFO of ALU results with sticky overrun flag
// ALU_RESULT_FIFO_STATS_EN adds saturating carry_cnt/zero_cnt push counters.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_carry,
  input  logic                     in_zero,
  input  logic [2:0]               in_opcode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic [2:0]               out_opcode,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_overflow
`ifdef ALU_RESULT_FIFO_STATS_EN
  ,
  output logic [15:0]              carry_cnt,
  output logic [15:0]              zero_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + 5;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push, pop;
  logic [EW-1:0] head;
  assign in_ready  = count < CW'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = out_valid ? mem[rptr] : '0;
  assign {out_opcode, out_carry, out_zero, out_result} = head;
  // power-of-two DEPTH lets pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wptr     <= wptr + AW'(push);
      rptr     <= rptr + AW'(pop);
      count    <= count + CW'(push) - CW'(pop);
      overflow <= (in_valid && !in_ready) || (overflow && !clr_overflow);
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {in_opcode, in_carry, in_zero, in_result};
`ifdef ALU_RESULT_FIFO_STATS_EN
  alu_sat_counter #(.WIDTH(16)) u_carry_cnt (
    .clk(clk), .rst_n(rst_n), .inc(push && in_carry), .cnt(carry_cnt)
  );
  alu_sat_counter #(.WIDTH(16)) u_zero_cnt (
    .clk(clk), .rst_n(rst_n), .inc(push && in_zero), .cnt(zero_cnt)
  );
`endif
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: randomized + directed check of alu_result_fifo against a queue model
module tb_alu_result_fifo;
  import alu_pkg::*;
  localparam int DEPTH = 4;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, in_carry = 1'b0, in_zero = 1'b0, out_ready = 1'b0, clr_overflow = 1'b0;
  logic [7:0] in_result = '0;
  logic [2:0] in_opcode = '0;
  logic       in_ready, out_valid, out_carry, out_zero, overflow;
  logic [7:0] out_result;
  logic [2:0] out_opcode;
  logic [2:0] count;
`ifdef ALU_RESULT_FIFO_STATS_EN
  logic [15:0] carry_cnt, zero_cnt;
`endif
  int checks = 0, failures = 0;
  int carry_m = 0, zero_m = 0;
  alu_entry_t q[$];
  bit ovf_m = 1'b0;
  always #5 clk = ~clk;
  alu_result_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_carry(in_carry), .in_zero(in_zero), .in_opcode(in_opcode),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero), .out_opcode(out_opcode),
    .count(count), .overflow(overflow), .clr_overflow(clr_overflow)
`ifdef ALU_RESULT_FIFO_STATS_EN
    , .carry_cnt(carry_cnt), .zero_cnt(zero_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_outs();
    alu_entry_t h;
    h = q.size() != 0 ? q[0] : '0;
    chk("count", 32'(count), q.size());
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_result", 32'(out_result), 32'(h.result));
    chk("out_carry", 32'(out_carry), 32'(h.carry));
    chk("out_zero", 32'(out_zero), 32'(h.zero));
    chk("out_opcode", 32'(out_opcode), 32'(h.opcode));
    chk("overflow", 32'(overflow), 32'(ovf_m));
`ifdef ALU_RESULT_FIFO_STATS_EN
    chk("carry_cnt", 32'(carry_cnt), carry_m);
    chk("zero_cnt", 32'(zero_cnt), zero_m);
`endif
  endtask
  task automatic cyc(input logic v, input logic [7:0] res, input logic c, input logic z,
                     input logic [2:0] op, input logic rdy, input logic clr);
    bit full, push, pop;
    in_valid = v; in_result = res; in_carry = c; in_zero = z; in_opcode = op;
    out_ready = rdy; clr_overflow = clr;
    full = q.size() == DEPTH;
    push = v && !full;
    pop  = rdy && q.size() != 0;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back('{alu_op_t'(op), c, z, res});
      carry_m += int'(c);
      zero_m  += int'(z);
    end
    if (v && full) ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    #1 check_outs();
  endtask
  task automatic idle(input logic rdy);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, rdy, 1'b0);
  endtask
  initial begin
    #12 check_outs();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    idle(1'b0);
    cyc(1'b1, 8'h00, 1'b1, 1'b1, ADD, 1'b0, 1'b0);
    idle(1'b1);
    for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(8'h11 * i), 1'b0, 1'b0, 3'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    cyc(1'b1, 8'h01, 1'b0, 1'b0, SUB, 1'b0, 1'b0);
    cyc(1'b1, 8'h02, 1'b0, 1'b0, SUB, 1'b0, 1'b0);
    for (int i = 3; i <= 12; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, XOR, 1'b1, 1'b0);
    cyc(1'b1, 8'hA0, 1'b1, 1'b0, OR, 1'b0, 1'b0);
    cyc(1'b1, 8'hA1, 1'b0, 1'b1, OR, 1'b0, 1'b0);
    cyc(1'b1, 8'hA2, 1'b1, 1'b0, OR, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'($urandom), 1'b1, 1'b1, SHL, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    q.delete(); ovf_m = 1'b0; carry_m = 0; zero_m = 0;
    #1 check_outs();
    @(negedge clk) rst_n = 1'b1;
    cyc(1'b1, 8'h5A, 1'b1, 1'b0, SHR, 1'b0, 1'b0);
    idle(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
